// File: rtl/red_pitaya_rst_pkg.sv
// Shared definitions for the Red Pitaya reset sequencer.
//   rst_state_t : 3-bit FSM state encoding, also exported on the debug port
//   SAT_LIMIT   : ceiling of the 8-bit status counters
//   max_of      : helper for sizing the shared cycle counter
//   sat_inc     : saturating increment with priority clear
package red_pitaya_rst_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4
  } rst_state_t;

  localparam logic [7:0] SAT_LIMIT = 8'hFF;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear has priority over an increment landing on the same cycle.
  function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic inc,
                                         input logic clr);
    if (clr) return 8'h00;
    if (inc && (v != SAT_LIMIT)) return v + 8'd1;
    return v;
  endfunction

endpackage

// File: rtl/red_pitaya_sync.sv
// Multi-flop synchronizer for signals arriving from another clock domain.
// Ports:
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage to 0
//   d   : asynchronous input bus (each bit synchronized independently)
//   q   : output of the last stage
module red_pitaya_sync #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/red_pitaya_rst_seq.sv
// Reset sequencer that sits directly behind the system PLL and runs on the
// PLL reference clock. Pulses the PLL reset, waits for a stable lock, then
// releases the domain resets one by one. Lock loss after release starts pulls
// every domain back into reset; a lock timeout re-pulses the PLL reset.
// Ports:
//   clk, rst    : reference clock, synchronous active-high reset
//   pll_locked  : PLL lock, asynchronous to clk
//   clr_cnt     : one-cycle pulse clearing lost_cnt and tmo_cnt
//   pll_rst     : PLL reset request (active high)
//   dom_rstn    : per-domain resets (active low), bit 0 released first
//   ready       : all domains released and lock stable
//   state       : current FSM state (rst_state_t encoding)
//   lost_cnt    : saturating count of lock losses in RELEASE/RUN
//   tmo_cnt     : saturating count of WAIT_LOCK timeouts
// Every output comes straight from a flop.
module red_pitaya_rst_seq
  import red_pitaya_rst_pkg::*;
#(
  parameter int N_DOM       = 4,
  parameter int PLL_RST_LEN = 8,
  parameter int LOCK_STABLE = 1024,
  parameter int STEP_DLY    = 16,
  parameter int LOCK_TMO    = 1048576
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             clr_cnt,
  output logic             pll_rst,
  output logic [N_DOM-1:0] dom_rstn,
  output logic             ready,
  output logic [2:0]       state,
  output logic [7:0]       lost_cnt,
  output logic [7:0]       tmo_cnt
);

  localparam int MAX_P = max_of(max_of(PLL_RST_LEN, LOCK_STABLE),
                                max_of(STEP_DLY, LOCK_TMO));
  localparam int CNT_W = $clog2(MAX_P) + 1;

  // Terminal values of the shared counter in each timed state.
  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(PLL_RST_LEN - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(LOCK_TMO - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_DLY - 1);

  logic lock_s;

  red_pitaya_sync #(
    .STAGES (2),
    .WIDTH  (1)
  ) u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lock_s)
  );

  rst_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pll_rst_q, pll_rst_d;
  logic [N_DOM-1:0] dom_rstn_q, dom_rstn_d;
  logic             ready_q, ready_d;
  logic [7:0]       lost_cnt_q, lost_cnt_d;
  logic [7:0]       tmo_cnt_q, tmo_cnt_d;
  logic             lost_inc, tmo_inc;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    dom_rstn_d = dom_rstn_q;
    lost_inc   = 1'b0;
    tmo_inc    = 1'b0;

    case (state_q)
      ST_PLL_RST: begin
        dom_rstn_d = '0;
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end

      ST_WAIT_LOCK: begin
        dom_rstn_d = '0;
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
          tmo_inc = 1'b1;
        end
      end

      // A dropout before release restarts the timeout window but is not a
      // loss: nothing downstream has come out of reset yet.
      ST_STABLE: begin
        dom_rstn_d = '0;
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end

      // Each STEP_DLY window shifts one more '1' in from the bottom, so bit k
      // rises after (k+1)*STEP_DLY cycles in this state.
      ST_RELEASE: begin
        if (!lock_s) begin
          state_d    = ST_WAIT_LOCK;
          cnt_d      = '0;
          dom_rstn_d = '0;
          lost_inc   = 1'b1;
        end else if (cnt_q == STEP_LAST) begin
          cnt_d      = '0;
          dom_rstn_d = (dom_rstn_q << 1) | N_DOM'(1);
          if (dom_rstn_d[N_DOM-1]) state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        cnt_d      = cnt_q;
        dom_rstn_d = '1;
        if (!lock_s) begin
          state_d    = ST_WAIT_LOCK;
          cnt_d      = '0;
          dom_rstn_d = '0;
          lost_inc   = 1'b1;
        end
      end

      default: begin
        state_d    = ST_PLL_RST;
        cnt_d      = '0;
        dom_rstn_d = '0;
      end
    endcase

    // Registered from the next state so the outputs line up with the state.
    pll_rst_d  = (state_d == ST_PLL_RST);
    ready_d    = (state_d == ST_RUN);
    lost_cnt_d = sat_inc(lost_cnt_q, lost_inc, clr_cnt);
    tmo_cnt_d  = sat_inc(tmo_cnt_q, tmo_inc, clr_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PLL_RST;
      cnt_q      <= '0;
      pll_rst_q  <= 1'b1;
      dom_rstn_q <= '0;
      ready_q    <= 1'b0;
      lost_cnt_q <= 8'h00;
      tmo_cnt_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pll_rst_q  <= pll_rst_d;
      dom_rstn_q <= dom_rstn_d;
      ready_q    <= ready_d;
      lost_cnt_q <= lost_cnt_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign pll_rst  = pll_rst_q;
  assign dom_rstn = dom_rstn_q;
  assign ready    = ready_q;
  assign state    = state_q;
  assign lost_cnt = lost_cnt_q;
  assign tmo_cnt  = tmo_cnt_q;

endmodule
